ps2_key_cmd: RTL and testbench
==============================

# ps2_key_cmd

PS/2 keyboard front end for the game board. Receives raw PS/2 frames from the `ps2_clock`/`ps2_data` pins and validates them. It strips break and extended prefixes, maps make codes to 3-bit game commands, and buffers them in a small FIFO. The FIFO feeds the game logic's `keyboard_ready`/`keyboard_data`/`keyboard_read_fin` handshake.

## Interface
- `TIMEOUT_CYCLES`, default 200_000: idle clock cycles (2 ms at 100 MHz) after which a partial frame is aborted.
- `FIFO_DEPTH`, default 4: command FIFO entries; must be a power of 2.
- `clock`, in, 1: system clock (100 MHz).
- `reset_n`, in, 1: asynchronous active-low reset.
- `ps2_clock`, in, 1: raw PS/2 clock pin, asynchronous.
- `ps2_data`, in, 1: raw PS/2 data pin, asynchronous.
- `read_fin`, in, 1: consumer acknowledge; each rising edge pops one command.
- `ready`, out, 1: FIFO non-empty.
- `data`, out, 3: command at the FIFO head. Valid while `ready`=1.
- `frame_err`, out, 1: one-cycle pulse for each frame that is discarded.
- `overflow`, out, 1: sticky; set when a command is dropped because the FIFO is full; cleared only by reset.

## Operation
- **Input sync:** `ps2_clock`, `ps2_data` and `read_fin` each pass through 2 flops. Falling edge of PS/2 clock = previous synced value 1 and current synced value 0.
- **Frame receiver:**
  - 11-bit frame, sampled on each falling edge: start (0), 8 data bits LSB first, odd parity, stop (1). Bit counter runs 0..10.
  - Start bit = 1: ignored, counter stays 0, no error.
  - Bad parity or stop = 0: byte discarded, `frame_err` pulses, counter returns to 0.
  - Timeout: cycle counter clears on every falling edge. If counter ≠ 0 and `TIMEOUT_CYCLES` cycles pass with no edge, the frame aborts, counter returns to 0 and `frame_err` pulses.
- **Prefix FSM** (states NORM, EXT, BRK, EXT_BRK; reset to NORM):
  - NORM: E0 → EXT; F0 → BRK; other byte → map with the normal table, stay NORM.
  - EXT: F0 → EXT_BRK; other byte → map with the extended table, return to NORM.
  - BRK or EXT_BRK: any byte → NORM, no command emitted.
  - Any `frame_err` → NORM.
- **Normal table:**
  - W 1D → 1 (up), S 1B → 2 (down), A 1C → 3 (left), D 23 → 4 (right).
  - Space 29 → 5 (select), Z 1A → 6 (half move), Enter 5A → 7 (end step).
- **Extended table:** 75 → 1, 72 → 2, 6B → 3, 74 → 4.
- **Unmapped bytes:** dropped silently. Command 0 is never emitted.
- **Typematic repeats:** every make byte, including auto-repeat, yields one command.
- **FIFO:**
  - Circular buffer with pointers one bit wider than the index; full = index bits equal and MSB differs.
  - `data` driven from the head entry. Held stable while `ready`=1 and no pop occurs.
  - Push when full and no pop in the same cycle: command dropped, `overflow` set.
  - Push and pop in the same cycle: both are performed, nothing is dropped, count is unchanged.
  - Pop when empty: ignored.
- **Reset values:** `ready`=0, `data`=0, `frame_err`=0, `overflow`=0, FIFO empty, FSM NORM, bit counter 0, timeout counter 0. Reset asserted mid-frame discards the frame; no `frame_err`.

## Timing
- **Edge detection:** a pin falling edge is detected 3 clock edges after it reaches `ps2_clock` (2 sync stages + edge register).
- **Decode:** on the stop-bit edge the byte is complete in the edge-detect cycle. Decode is registered 1 cycle later; the FIFO write happens the cycle after that.
- **Latency to `ready`:** `ready` goes high exactly 5 rising edges after the stop-bit falling edge on the pin, when the FIFO was empty.
- **Pop:** the `read_fin` 0→1 transition is detected 3 edges after the pin change. The pop takes effect on that edge. `ready` and `data` show the new head from the next cycle.
- **Held acknowledge:** `read_fin` held high pops exactly once.
- **Throughput:** at most one command per PS/2 frame (~1 ms). The FIFO absorbs consumer latency only.

## Test plan
- Frame 1D with correct parity → `ready`=1 with `data`=1 after 5 cycles. One `read_fin` pulse → `ready`=0.
- Sequence E0 75, then E0 F0 75 → exactly one command, 1. Sequence F0 1D → no command.
- Byte 29 with wrong parity → `frame_err` pulses once, no command. A following valid 23 → `data`=4.
- 6 start + data bits of a frame, then idle for `TIMEOUT_CYCLES`+10 → `frame_err` pulses. A following full 5A frame → `data`=7.
- Five commands 1D, 1B, 1C, 23, 29 with no pops → first four are buffered, `overflow`=1. Four pops return 1, 2, 3, 4, then `ready`=0.
- FIFO full with `read_fin` rising in the same cycle as a push → no drop, `overflow` stays 0, order preserved. `reset_n` pulsed mid-frame → all outputs 0.

Source files
------------

// File: rtl/ps2_key_cmd.sv
// ps2_key_cmd: PS/2 keyboard receiver, prefix decoder and command FIFO for the game logic
module ps2_key_cmd #(
  parameter int TIMEOUT_CYCLES = 200_000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  input  logic       read_fin,
  output logic       ready,
  output logic [2:0] data,
  output logic       frame_err,
  output logic       overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] NORM = 2'd0, EXT = 2'd1, BRK = 2'd2, EXT_BRK = 2'd3;

  logic [1:0]    clk_sync, dat_sync, fin_sync;
  logic          clk_prev, fin_prev, fall, fin_rise;
  logic [3:0]    bit_cnt;
  logic [7:0]    shift, rx_byte;
  logic          par, byte_v;
  logic [TW-1:0] idle_cnt;
  logic [1:0]    state;
  logic [2:0]    cmd;
  logic          cmd_v;
  logic [2:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, do_pop, do_push;

  function automatic logic [2:0] map_norm(input logic [7:0] b);
    case (b)
      8'h1D:   return 3'd1;
      8'h1B:   return 3'd2;
      8'h1C:   return 3'd3;
      8'h23:   return 3'd4;
      8'h29:   return 3'd5;
      8'h1A:   return 3'd6;
      8'h5A:   return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] map_ext(input logic [7:0] b);
    case (b)
      8'h75:   return 3'd1;
      8'h72:   return 3'd2;
      8'h6B:   return 3'd3;
      8'h74:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  assign fall     = clk_prev & ~clk_sync[1];
  assign fin_rise = fin_sync[1] & ~fin_prev;

  // two-flop synchronizers for the asynchronous pins plus edge-history registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync <= '0;
      dat_sync <= '0;
      fin_sync <= '0;
      clk_prev <= 1'b0;
      fin_prev <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clock};
      dat_sync <= {dat_sync[0], ps2_data};
      fin_sync <= {fin_sync[0], read_fin};
      clk_prev <= clk_sync[1];
      fin_prev <= fin_sync[1];
    end
  end

  // frame receiver: start, 8 data bits LSB first, odd parity, stop, with idle abort
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt   <= '0;
      shift     <= '0;
      par       <= 1'b0;
      idle_cnt  <= '0;
      byte_v    <= 1'b0;
      rx_byte   <= '0;
      frame_err <= 1'b0;
    end else begin
      byte_v    <= 1'b0;
      frame_err <= 1'b0;
      if (fall) begin
        idle_cnt <= '0;
        if (bit_cnt == 4'd0) begin
          bit_cnt <= dat_sync[1] ? 4'd0 : 4'd1;
        end else if (bit_cnt != 4'd10) begin
          if (bit_cnt == 4'd9) par <= dat_sync[1];
          else shift <= {dat_sync[1], shift[7:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end else begin
          bit_cnt <= 4'd0;
          if (dat_sync[1] && (^{shift, par})) begin
            byte_v  <= 1'b1;
            rx_byte <= shift;
          end else begin
            frame_err <= 1'b1;
          end
        end
      end else if (bit_cnt != 4'd0) begin
        if (idle_cnt == T_LAST) begin
          bit_cnt   <= 4'd0;
          idle_cnt  <= '0;
          frame_err <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end
  end

  // prefix tracking (E0 / F0) and make-code to command mapping
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= NORM;
      cmd   <= '0;
      cmd_v <= 1'b0;
    end else begin
      cmd_v <= 1'b0;
      if (frame_err) begin
        state <= NORM;
      end else if (byte_v) begin
        case (state)
          NORM: begin
            if (rx_byte == 8'hE0) state <= EXT;
            else if (rx_byte == 8'hF0) state <= BRK;
            else begin
              cmd   <= map_norm(rx_byte);
              cmd_v <= |map_norm(rx_byte);
            end
          end
          EXT: begin
            if (rx_byte == 8'hF0) state <= EXT_BRK;
            else begin
              state <= NORM;
              cmd   <= map_ext(rx_byte);
              cmd_v <= |map_ext(rx_byte);
            end
          end
          BRK, EXT_BRK: state <= NORM;
        endcase
      end
    end
  end

  // FIFO control: a pop frees the slot a same-cycle push needs, so full+pop never drops
  always_comb begin
    empty   = wr_ptr == rd_ptr;
    full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    do_pop  = fin_rise && !empty;
    do_push = cmd_v && (!full || do_pop);
  end

  // FIFO pointers and sticky overflow flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (cmd_v && !do_push) overflow <= 1'b1;
    end
  end

  // FIFO storage; contents are only visible through the gated head output
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= cmd;
  end

  assign ready = !empty;
  assign data  = ready ? mem[rd_ptr[AW-1:0]] : 3'd0;
endmodule

// File: tb/tb_ps2_key_cmd.sv
// tb_ps2_key_cmd: directed PS/2 frame stimulus with hand-computed expected commands
module tb_ps2_key_cmd;
  localparam int TO   = 200;
  localparam int HALF = 10;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clock = 1'b1;
  logic       ps2_data = 1'b1;
  logic       read_fin = 1'b0;
  logic       ready, frame_err, overflow;
  logic [2:0] data;
  int         total = 0, bad = 0, ferr_cnt = 0, f0;

  ps2_key_cmd #(.TIMEOUT_CYCLES(TO), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset_n(reset_n), .ps2_clock(ps2_clock), .ps2_data(ps2_data),
    .read_fin(read_fin), .ready(ready), .data(data), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clock = ~clock;

  // count frame_err pulses sampled mid-cycle
  always @(negedge clock) if (frame_err) ferr_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_raw(input logic [7:0] b, input logic bad_par, input int n);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      ticks(HALF);
      ps2_clock = 1'b0;
      if (i < n - 1) begin
        ticks(HALF);
        ps2_clock = 1'b1;
      end
    end
  endtask

  task automatic release_clk();
    ticks(HALF);
    ps2_clock = 1'b1;
    ps2_data  = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    send_raw(b, 1'b0, 11);
    release_clk();
    ticks(10);
  endtask

  task automatic pop();
    read_fin = 1'b1;
    ticks(6);
    read_fin = 1'b0;
    ticks(6);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ready"}, ready, 0);
    check({tag, "_data"}, data, 0);
    check({tag, "_ferr"}, frame_err, 0);
    check({tag, "_ovf"}, overflow, 0);
  endtask

  initial begin
    ticks(3);
    check_zero("rst");
    reset_n = 1'b1;
    ticks(3);

    send_raw(8'h1D, 1'b0, 11);
    ticks(4);
    check("lat4_ready", ready, 0);
    ticks(1);
    check("lat5_ready", ready, 1);
    check("lat5_data", data, 1);
    release_clk();
    ticks(10);
    pop();
    check("pop1_ready", ready, 0);

    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    check("ext_ready", ready, 1);
    check("ext_data", data, 1);
    pop();
    check("ext_single", ready, 0);
    send(8'hF0); send(8'h1D);
    check("brk_none", ready, 0);

    f0 = ferr_cnt;
    send_raw(8'h29, 1'b1, 11);
    release_clk();
    ticks(10);
    check("par_ferr", ferr_cnt - f0, 1);
    check("par_ready", ready, 0);
    send(8'h23);
    check("after_par_data", data, 4);
    pop();

    f0 = ferr_cnt;
    send_raw(8'h5A, 1'b0, 6);
    release_clk();
    ticks(TO + 10);
    check("to_ferr", ferr_cnt - f0, 1);
    check("to_ready", ready, 0);
    send(8'h5A);
    check("after_to_data", data, 7);
    pop();
    check("after_to_empty", ready, 0);

    send(8'h1D); send(8'h1B); send(8'h1C); send(8'h23);
    check("full_ovf0", overflow, 0);
    send(8'h29);
    check("ovf_set", overflow, 1);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("ovf_pop%0d", i), data, i);
      pop();
    end
    check("ovf_empty", ready, 0);
    check("ovf_sticky", overflow, 1);

    reset_n = 1'b0;
    ticks(2);
    check("rst2_ovf", overflow, 0);
    reset_n = 1'b1;
    ticks(3);
    send(8'h1D); send(8'h1B); send(8'h1C); send(8'h23);
    send_raw(8'h29, 1'b0, 11);
    ticks(2);
    read_fin = 1'b1;
    ticks(3);
    release_clk();
    read_fin = 1'b0;
    ticks(10);
    check("sim_ovf", overflow, 0);
    for (int i = 2; i <= 5; i++) begin
      check($sformatf("sim_pop%0d", i), data, i);
      pop();
    end
    check("sim_empty", ready, 0);

    send(8'h1D);
    send_raw(8'h1B, 1'b0, 6);
    reset_n = 1'b0;
    #1;
    check_zero("midrst");
    ticks(2);
    release_clk();
    f0 = ferr_cnt;
    reset_n = 1'b1;
    ticks(TO + 20);
    check("midrst_noferr", ferr_cnt - f0, 0);
    check("midrst_ready", ready, 0);
    send(8'h1C);
    check("midrst_recover", data, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
